joybus_rx: RTL and testbench

JOYBUS_RX -- requirements
Module: joybus_rx

---
 rtl/joybus_rx.sv | 152 +++++++++++++++
 tb/tb_joybus_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/joybus_rx.sv
// Joybus receiver: classifies low-pulse widths into data 0/1 or stop, assembles MSB-first bytes,
// and reports frame completion or malformed frames, with a quiet-line recovery wait after errors.
module joybus_rx #(
  parameter int CLKS_PER_Q = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy,
  output logic [5:0] byte_cnt
);

  localparam int CW = $clog2(4*CLKS_PER_Q+2);
  localparam logic [CW-1:0] C_T1    = CW'(3*CLKS_PER_Q/2);
  localparam logic [CW-1:0] C_T2    = CW'(5*CLKS_PER_Q/2);
  localparam logic [CW-1:0] C_MAX   = CW'(4*CLKS_PER_Q);
  localparam logic [CW-1:0] C_MAXM1 = CW'(4*CLKS_PER_Q-1);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_RECOVER} state_t;

  logic          r_s1, r_s2, r_prev;
  logic [1:0]    r_warm;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte_data;
  logic [5:0]    r_byte_cnt;
  logic          r_byte_valid, r_frame_done, r_frame_err, r_busy;

  logic          w_armed, w_fall, w_rise, w_bit, w_is_stop;
  logic [CW-1:0] w_cnt_inc;
  logic [7:0]    w_next;

  // Edges only count once the synchronizer holds real samples, so a line
  // held low through reset release never looks like a falling edge.
  assign w_armed   = (r_warm == 2'd3);
  assign w_fall    = w_armed &  r_prev & ~r_s2;
  assign w_rise    = w_armed & ~r_prev &  r_s2;
  assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + 1'b1;
  assign w_bit     = (r_cnt < C_T1);
  assign w_is_stop = (r_cnt >= C_T1) && (r_cnt < C_T2);
  assign w_next    = {r_shift[6:0], w_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_prev <= 1'b1;
      r_warm <= 2'd0;
    end else begin
      r_s1   <= rx;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_byte_data  <= 8'd0;
      r_byte_cnt   <= 6'd0;
      r_byte_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state    <= S_LOW;
            r_cnt      <= CW'(1);
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 6'd0;
            r_busy     <= 1'b1;
          end
        end
        S_LOW: begin
          if (w_rise) begin
            r_cnt <= CW'(1);
            if (w_is_stop) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              if (r_bit_cnt == 3'd0 && r_byte_cnt != 6'd0) r_frame_done <= 1'b1;
              else                                         r_frame_err  <= 1'b1;
            end else begin
              r_state <= S_HIGH;
              r_shift <= w_next;
              if (r_bit_cnt == 3'd7) begin
                r_bit_cnt    <= 3'd0;
                r_byte_data  <= w_next;
                r_byte_valid <= 1'b1;
                if (r_byte_cnt != 6'd63) r_byte_cnt <= r_byte_cnt + 6'd1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
          end else if (r_cnt == C_MAX) begin
            r_state     <= S_RECOVER;
            r_frame_err <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_HIGH: begin
          if (w_fall) begin
            r_state <= S_LOW;
            r_cnt   <= CW'(1);
          end else if (r_cnt == C_MAX) begin
            r_state     <= S_IDLE;
            r_frame_err <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RECOVER: begin
          // Any low sample restarts the quiet-line wait.
          if (!r_s2) begin
            r_cnt <= '0;
          end else if (r_cnt == C_MAXM1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign byte_data  = r_byte_data;
  assign byte_valid = r_byte_valid;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;
  assign byte_cnt   = r_byte_cnt;

endmodule

// File: tb/tb_joybus_rx.sv
// Scoreboard bench for joybus_rx: a pulse-level reference model predicts byte/done/err events.
module tb_joybus_rx;

  localparam int Q    = 50;
  localparam int T1   = 3*Q/2;
  localparam int T2   = 5*Q/2;
  localparam int TMAX = 4*Q;
  localparam int K_BYTE = 0, K_DONE = 1, K_ERR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid, frame_done, frame_err, busy;
  logic [5:0] byte_cnt;

  joybus_rx #(.CLKS_PER_Q(Q)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .byte_data(byte_data), .byte_valid(byte_valid), .frame_done(frame_done),
    .frame_err(frame_err), .busy(busy), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int data; int cnt; } ev_t;
  ev_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  bit m_in_frame = 0, m_recover = 0;
  int m_bits = 0, m_shift = 0, m_nbytes = 0;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(int k, int d, int c);
    ev_t e;
    e.kind = k; e.data = d; e.cnt = c;
    exp_q.push_back(e);
  endfunction

  // Reference model: one call per low pulse, one per high gap.
  function automatic void model_pulse(int L);
    if (m_recover) return;
    if (!m_in_frame) begin
      m_in_frame = 1; m_bits = 0; m_nbytes = 0; m_shift = 0;
    end
    if (L > TMAX) begin
      push(K_ERR, 0, 0); m_in_frame = 0; m_recover = 1;
    end else if (L >= T1 && L < T2) begin
      if (m_bits == 0 && m_nbytes >= 1) push(K_DONE, 0, m_nbytes);
      else push(K_ERR, 0, 0);
      m_in_frame = 0;
    end else begin
      m_shift = ((m_shift << 1) | ((L < T1) ? 1 : 0)) & 255;
      m_bits++;
      if (m_bits == 8) begin
        m_bits = 0;
        if (m_nbytes < 63) m_nbytes++;
        push(K_BYTE, m_shift, m_nbytes);
      end
    end
  endfunction

  function automatic void model_gap(int h);
    if (m_recover) begin
      if (h >= TMAX) m_recover = 0;
    end else if (m_in_frame && h > TMAX) begin
      push(K_ERR, 0, 0); m_in_frame = 0;
    end
  endfunction

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(int L, int h);
    model_pulse(L);
    rx = 1'b0;
    repeat (L) @(posedge clk);
    #1 rx = 1'b1;
    model_gap(h);
    repeat (h) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(int b, int hi, int lo);
    for (int i = hi; i >= lo; i--)
      pulse(b[i] ? $urandom_range(2, T1-1) : $urandom_range(T2, TMAX), $urandom_range(10, 60));
  endtask

  task automatic stop(int L);
    pulse(L, 250);
  endtask

  // Monitor: pops an expectation for every output pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      int n;
      int k;
      ev_t e;
      n = int'(byte_valid) + int'(frame_done) + int'(frame_err);
      if (n > 1) begin
        n_cmp++; n_err++;
        $display("FAIL pulse_overlap: got %0d pulses in one cycle, expected 1", n);
      end
      if (n != 0) begin
        k = byte_valid ? K_BYTE : (frame_done ? K_DONE : K_ERR);
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_event: got kind %0d, expected none (t=%0t)", k, $time);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", k, e.kind);
          if (e.kind == K_BYTE) begin
            check("byte_data", int'(byte_data), e.data);
            check("byte_cnt", int'(byte_cnt), e.cnt);
          end else if (e.kind == K_DONE) begin
            check("done_byte_cnt", int'(byte_cnt), e.cnt);
          end
        end
      end
    end
  end

  initial begin
    // Reset released with the line held low: no frame may start.
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(50);
    check("rst_busy", int'(busy), 0);
    check("rst_byte_data", int'(byte_data), 0);
    check("rst_byte_cnt", int'(byte_cnt), 0);
    rx = 1'b1;
    idle(20);

    // Single byte 0x01 then stop.
    send_bits(8'h01, 7, 0);
    stop(100);
    check("b01_data", int'(byte_data), 8'h01);
    check("b01_cnt", int'(byte_cnt), 1);
    check("b01_busy", int'(busy), 0);

    // 0xA5, 0x3C then stop; busy observed mid-pulse of the first bit.
    model_pulse(40);
    rx = 1'b0;
    idle(20);
    check("busy_mid", int'(busy), 1);
    idle(20);
    rx = 1'b1;
    model_gap(30);
    idle(30);
    send_bits(8'hA5, 6, 0);
    send_bits(8'h3C, 7, 0);
    stop(90);
    check("two_cnt", int'(byte_cnt), 2);
    check("two_data", int'(byte_data), 8'h3C);

    // Five bits then stop: partial byte error.
    send_bits(8'h16, 4, 0);
    stop(100);
    check("partial_busy", int'(busy), 0);

    // Long low, an ignored pulse in recovery, then a valid frame.
    pulse(250, 100);
    pulse(30, 210);
    send_bits(8'h5A, 7, 0);
    stop(110);
    check("recov_data", int'(byte_data), 8'h5A);
    check("recov_busy", int'(busy), 0);

    // Boundary widths: 74/125/200 as data, 75 and 124 as stop, 201 as error.
    begin
      int w[8] = '{74, 125, 200, 74, 125, 200, 74, 74};
      for (int i = 0; i < 8; i++) pulse(w[i], 30);
    end
    stop(75);
    check("bound_data", int'(byte_data), 8'h93);
    send_bits(8'h6E, 7, 0);
    stop(124);
    pulse(201, 250);
    check("err201_busy", int'(busy), 0);
    stop(100);

    // Missing stop: line stays high after a byte.
    send_bits(8'hC3, 7, 0);
    model_gap(250);
    idle(250);
    check("nostop_busy", int'(busy), 0);

    // Random frames, some with a trailing partial byte.
    for (int f = 0; f < 12; f++) begin
      int nb = $urandom_range(1, 2);
      for (int b = 0; b < nb; b++) send_bits($urandom_range(0, 255), 7, 0);
      if ($urandom_range(0, 3) == 0) send_bits($urandom_range(0, 255), 7, $urandom_range(1, 7));
      stop($urandom_range(T1, T2-1));
    end

    // Reset mid-byte, then a fresh 0xFF frame.
    send_bits(8'hF0, 7, 4);
    rx = 1'b0;
    idle(20);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", int'(byte_data), 0);
    check("mid_rst_cnt", int'(byte_cnt), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_pulses", int'(byte_valid) + int'(frame_done) + int'(frame_err), 0);
    m_in_frame = 0; m_recover = 0;
    exp_q.delete();
    rx = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(10);
    send_bits(8'hFF, 7, 0);
    stop(100);
    check("ff_data", int'(byte_data), 8'hFF);
    check("ff_cnt", int'(byte_cnt), 1);

    idle(300);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
